xnor_match_window: RTL and testbench

//  Downstream consumer of the XNOR equality stage: takes its per-cycle Y bit (1 = A matched B)
//  and counts matches over a fixed window of WINDOW accepted bits. Reports the match count and a

---
 rtl/xnor_pkg.sv | 14 +
 rtl/xnor_match_window.sv | 118 +++++++++++
 tb/tb_xnor_match_window.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/xnor_pkg.sv
// Shared definitions for the XNOR equality stage and its match-window consumer.
// Holds the FSM state encoding and the default window/threshold constants.
package xnor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned DEF_WINDOW = 8;
    localparam int unsigned DEF_THRESH = 6;

endpackage

// File: rtl/xnor_match_window.sv
// Counts XNOR match bits over a window of WINDOW accepted bits and reports count/pass via valid/ready.
// Define XNOR_MATCH_RUN_EN to add the max_run output (longest run of consecutive matches).
module xnor_match_window
    import xnor_pkg::*;
#(
    parameter int unsigned WINDOW = DEF_WINDOW,
    parameter int unsigned THRESH = DEF_THRESH,
    parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] match_count,
    output logic             pass,
`ifdef XNOR_MATCH_RUN_EN
    output logic [CNT_W-1:0] max_run,
`endif
    output logic             busy
);

    state_e            r_state;
    state_e            w_state_next;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_match_count;
    logic              r_pass;

    logic              w_accept;
    logic              w_last;
    logic              w_enter;
    logic [CNT_W-1:0]  w_sum;
    logic              w_pass;

    assign w_accept = in_valid && (r_state == ACCUM);
    assign w_last   = w_accept && (r_bit_cnt == CNT_W'(WINDOW - 1));
    assign w_enter  = (r_state == IDLE) && start;
    assign w_sum    = r_acc + CNT_W'(Y);
    // Widened compare so THRESH above WINDOW simply never passes.
    assign w_pass   = (32'(w_sum) >= THRESH);

    assign in_ready    = (r_state == ACCUM);
    assign out_valid   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign match_count = r_match_count;
    assign pass        = r_pass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)     w_state_next = ACCUM;
            ACCUM:   if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt     <= '0;
            r_acc         <= '0;
            r_match_count <= '0;
            r_pass        <= 1'b0;
        end else if (w_enter) begin
            r_bit_cnt <= '0;
            r_acc     <= '0;
        end else if (w_accept) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_acc     <= w_sum;
            if (w_last) begin
                r_match_count <= w_sum;
                r_pass        <= w_pass;
            end
        end
    end

`ifdef XNOR_MATCH_RUN_EN
    logic [CNT_W-1:0]  r_run_cur;
    logic [CNT_W-1:0]  r_run_best;
    logic [CNT_W-1:0]  r_max_run;
    logic [CNT_W-1:0]  w_run_next;
    logic [CNT_W-1:0]  w_best_next;

    assign w_run_next  = Y ? (r_run_cur + 1'b1) : '0;
    assign w_best_next = (w_run_next > r_run_best) ? w_run_next : r_run_best;
    assign max_run     = r_max_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cur  <= '0;
            r_run_best <= '0;
            r_max_run  <= '0;
        end else if (w_enter) begin
            r_run_cur  <= '0;
            r_run_best <= '0;
        end else if (w_accept) begin
            r_run_cur  <= w_run_next;
            r_run_best <= w_best_next;
            if (w_last) begin
                r_max_run <= w_best_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xnor_match_window.sv
// Directed bench for xnor_match_window (WINDOW=8, THRESH=6); checks max_run when XNOR_MATCH_RUN_EN is set.
module tb_xnor_match_window;

    localparam int unsigned WINDOW = 8;
    localparam int unsigned THRESH = 6;
    localparam int unsigned CNT_W  = $clog2(WINDOW + 1);

    logic             clk;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             Y;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] match_count;
    logic             pass;
    logic             busy;
`ifdef XNOR_MATCH_RUN_EN
    logic [CNT_W-1:0] max_run;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    xnor_match_window #(
        .WINDOW (WINDOW),
        .THRESH (THRESH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Y           (Y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .match_count (match_count),
        .pass        (pass),
`ifdef XNOR_MATCH_RUN_EN
        .max_run     (max_run),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards are held through the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic y, input logic v);
        in_valid = v;
        Y        = y;
        step();
        in_valid = 1'b0;
        Y        = 1'b0;
    endtask

    task automatic feed_window(input logic [7:0] bits, input logic gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) feed(1'b1, 1'b0);
            feed(bits[i], 1'b1);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        Y         = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_match_count", 32'(match_count), 0);
        chk("rst_pass", 32'(pass), 0);
        rst = 1'b0;
        step();

        // Window 1: six matches, pass.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("w1_busy", 32'(busy), 1);
        chk("w1_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 7; i++) feed((i < 6) ? 1'b1 : 1'b0, 1'b1);
        chk("w1_no_early_valid", 32'(out_valid), 0);
        feed(1'b0, 1'b1);
        chk("w1_out_valid", 32'(out_valid), 1);
        chk("w1_in_ready_drop", 32'(in_ready), 0);
        chk("w1_match_count", 32'(match_count), 6);
        chk("w1_pass", 32'(pass), 1);
`ifdef XNOR_MATCH_RUN_EN
        chk("w1_max_run", 32'(max_run), 6);
`endif

        // Back-pressure in DONE with start held: everything stays put.
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_match_count", 32'(match_count), 6);
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drain_out_valid", 32'(out_valid), 0);
        chk("drain_busy", 32'(busy), 0);
        chk("drain_keep_count", 32'(match_count), 6);

        // Window 2: five matches with in_valid gaps (Y=1 during gaps must be ignored).
        start = 1'b1;
        step();
        start = 1'b0;
        feed_window(8'b1011_0011, 1'b1);
        chk("w2_out_valid", 32'(out_valid), 1);
        chk("w2_match_count", 32'(match_count), 5);
        chk("w2_pass", 32'(pass), 0);
`ifdef XNOR_MATCH_RUN_EN
        chk("w2_max_run", 32'(max_run), 2);
`endif

        // out_ready and start together in DONE: return to IDLE, start dropped.
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        chk("same_cycle_busy", 32'(busy), 0);
        step();
        chk("same_cycle_no_window", 32'(busy), 0);
        chk("same_cycle_in_ready", 32'(in_ready), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_busy", 32'(busy), 1);

        // Window 3: runs of 2, 3, 1.
        feed_window(8'b1101_1101, 1'b0);
        chk("w3_out_valid", 32'(out_valid), 1);
        chk("w3_match_count", 32'(match_count), 6);
        chk("w3_pass", 32'(pass), 1);
`ifdef XNOR_MATCH_RUN_EN
        chk("w3_max_run", 32'(max_run), 3);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a window.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) feed(1'b1, 1'b1);
        chk("mid_in_ready_pre", 32'(in_ready), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_match_count", 32'(match_count), 0);
        chk("mid_rst_pass", 32'(pass), 0);
`ifdef XNOR_MATCH_RUN_EN
        chk("mid_rst_max_run", 32'(max_run), 0);
`endif
        step();
        rst = 1'b0;
        step();
        chk("post_rst_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
